fft_loop_test_onchip_memory_dp: RTL

Parametrised dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2) on one clock. It is the next-generation scratch and sample buffer for the FFT loop test system.
- Adds configurable width, depth and read latency.
- Adds `readdatavalid` pipelining and a deterministic collision policy.
- Adds an optional hardware clear-on-reset sequencer that holds off both masters until memory contents are known.

---
 rtl/fft_loop_test_onchip_memory_dp.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fft_loop_test_onchip_memory_dp.sv
// fft_loop_test_onchip_memory_dp
//
// Dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2) on
// one clock. It is the scratch and sample buffer for the FFT loop test
// system. Features:
//   * Configurable word width, depth and read latency (1 or 2 cycles).
//   * A per-port readdatavalid pipeline.
//   * A deterministic collision policy:
//       - s1 wins each byte it enables on a same-address double write.
//       - A read always sees the pre-write contents.
//   * An optional clear-on-reset sequencer. It fills every word with
//     CLEAR_VALUE and holds off both masters until the fill is done.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   clken              global clock enable; all state freezes while low
//   sN_address         word address (N = 1, 2)
//   sN_byteenable      byte write mask
//   sN_chipselect      port select
//   sN_read/sN_write   request strobes
//   sN_writedata       write data
//   sN_readdata        read data; holds its last value between valids
//   sN_readdatavalid   sN_readdata carries a read result this cycle
//   sN_waitrequest     high while the clear sequence runs
//   busy               clear sequence in progress (or reset asserted)
//
// Handshake:
//   A request is accepted on an edge where all of the following hold:
//     chipselect & (read | write) & ~waitrequest & clken
//   If write and read are both set, only the write happens.
//   An accepted read produces exactly one readdatavalid cycle,
//   READ_LATENCY enabled edges later.
//   There is no back-pressure once the clear has finished.
module fft_loop_test_onchip_memory_dp #(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 15,
  parameter int                DEPTH          = 2**ADDR_W,
  parameter int                READ_LATENCY   = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t             state;
  logic [IDX_W-1:0]   clr_cnt;
  logic               clear_we;

  // Port-indexed views of the two slaves (index 0 = s1, 1 = s2).
  logic [ADDR_W-1:0]  addr     [2];
  logic [BE_W-1:0]    be       [2];
  logic               cs       [2];
  logic               rd       [2];
  logic               wr       [2];
  logic [DATA_W-1:0]  wdata    [2];
  logic               in_range [2];
  logic [IDX_W-1:0]   idx      [2];
  logic               acc      [2];
  logic               we       [2];
  logic               rd_acc   [2];
  logic [DATA_W-1:0]  rd_word  [2];

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [READ_LATENCY-1:0]  pv  [2];
  logic [DATA_W-1:0]        pd  [2][READ_LATENCY];

  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign cs[0]    = s1_chipselect;
  assign cs[1]    = s2_chipselect;
  assign rd[0]    = s1_read;
  assign rd[1]    = s2_read;
  assign wr[0]    = s1_write;
  assign wr[1]    = s2_write;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;

  // In reset the state register is CLEAR, so waitrequest/busy are already 1.
  assign busy           = (state == ST_CLEAR);
  assign s1_waitrequest = (state == ST_CLEAR);
  assign s2_waitrequest = (state == ST_CLEAR);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_range[p] = ({1'b0, addr[p]} < (ADDR_W+1)'(DEPTH));
      idx[p]      = addr[p][IDX_W-1:0];
      acc[p]      = cs[p] & (rd[p] | wr[p]) & (state == ST_READY) & clken;
      we[p]       = acc[p] & wr[p] & in_range[p];
      rd_acc[p]   = acc[p] & rd[p] & ~wr[p];
      // Combinational read of the array gives old-data-on-collision for free:
      // any same-edge write lands after this value is captured.
      rd_word[p]  = in_range[p] ? mem[idx[p]] : '0;
    end
  end

  assign clear_we = CLEAR_ON_RESET && (state == ST_CLEAR) && clken && !reset;

  // Clear sequencer. Reset forces CLEAR with the counter back at word 0.
  // The write to the last word also moves the FSM to READY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (clken && state == ST_CLEAR) begin
      if (!CLEAR_ON_RESET || clr_cnt == IDX_W'(DEPTH - 1)) begin
        state <= ST_READY;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Storage. s2 is written first and s1 last, so on a same-address double
  // write s1 overrides exactly the bytes it enables.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end
    for (int p = 1; p >= 0; p--) begin
      if (we[p]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[p][b]) begin
            mem[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
          end
        end
      end
    end
  end

  // Read pipelines: one valid bit and one data register per stage.
  // Data registers load only behind a valid bit, so readdata holds between
  // results. The pipelines freeze while clken is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        pv[p] <= '0;
        for (int s = 0; s < READ_LATENCY; s++) begin
          pd[p][s] <= '0;
        end
      end
    end else if (clken) begin
      for (int p = 0; p < 2; p++) begin
        pv[p][0] <= rd_acc[p];
        if (rd_acc[p]) begin
          pd[p][0] <= rd_word[p];
        end
        for (int s = 1; s < READ_LATENCY; s++) begin
          pv[p][s] <= pv[p][s-1];
          if (pv[p][s-1]) begin
            pd[p][s] <= pd[p][s-1];
          end
        end
      end
    end
  end

  assign s1_readdata      = pd[0][READ_LATENCY-1];
  assign s1_readdatavalid = pv[0][READ_LATENCY-1];
  assign s2_readdata      = pd[1][READ_LATENCY-1];
  assign s2_readdatavalid = pv[1][READ_LATENCY-1];

endmodule
